// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB master arbiter.
// Slave select comes from the top two address bits.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int NREQ_DEF = 2;
  localparam int AW_DEF   = 32;
  localparam int DW_DEF   = 32;
  localparam int TMO_DEF  = 16;

  localparam int SLV_SEL_MSB = AW_DEF - 1;
  localparam int SLV_SEL_LSB = AW_DEF - 2;
  localparam int SLV_SEL_W   = SLV_SEL_MSB - SLV_SEL_LSB + 1;

  function automatic logic [3:0] psel_decode(
    input logic [SLV_SEL_W-1:0] i_sel
  );
    return 4'b0001 << i_sel;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester and APB signal bundle of the arbiter.
// master = arbiter view, slave = environment view.
interface apb_master_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;

  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PWRITE;
  logic          PENABLE;
  logic          PSEL1;
  logic          PSEL2;
  logic          PSEL3;
  logic          PSEL4;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  modport master (
    input  req, req_write, req_addr, req_wdata,
    input  PRDATA, PREADY, PSLVERR,
    output done, rsp_rdata, rsp_err,
    output PADDR, PWDATA, PWRITE, PENABLE,
    output PSEL1, PSEL2, PSEL3, PSEL4
  );

  modport slave (
    output req, req_write, req_addr, req_wdata,
    output PRDATA, PREADY, PSLVERR,
    input  done, rsp_rdata, rsp_err,
    input  PADDR, PWDATA, PWRITE, PENABLE,
    input  PSEL1, PSEL2, PSEL3, PSEL4
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr.
// The pointer register is owned by the parent.
module apb_rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);
  always_comb begin : p_pick
    logic [PW:0] w_pos;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_pos >= (PW+1)'(NREQ))
        w_pos = w_pos - (PW+1)'(NREQ);
      if (!o_any && i_req[w_pos[PW-1:0]]) begin
        o_any                 = 1'b1;
        o_gnt[w_pos[PW-1:0]] = 1'b1;
        o_idx                 = w_pos[PW-1:0];
      end
    end
  end
endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master shared by NREQ requesters, 4-slave decode.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES waits.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ           = NREQ_DEF,
  parameter int AW             = AW_DEF,
  parameter int DW             = DW_DEF,
  parameter int TIMEOUT_CYCLES = TMO_DEF
) (
  input logic                  PCLK,
  input logic                  PRESET,
  apb_master_arbiter_if.master bus
);
  localparam int PW = $clog2(NREQ);

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, w_idx;
  logic [NREQ-1:0] r_win_oh, r_done;
  logic [NREQ-1:0] w_mask, w_gnt;
  logic            w_any, w_end, w_arb, w_tmo;
  logic [AW-1:0]   r_paddr;
  logic [DW-1:0]   r_pwdata, r_rdata;
  logic            r_pwrite, r_err;
  logic [3:0]      w_psel;
  logic [AW-1:0]   w_addr  [NREQ];
  logic [DW-1:0]   w_wdata [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr[g]  = bus.req_addr[g*AW +: AW];
    assign w_wdata[g] = bus.req_wdata[g*DW +: DW];
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)
      r_tmo_cnt <= '0;
    else if (r_state != ACCESS)
      r_tmo_cnt <= '0;
    else if (!bus.PREADY)
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_tmo = (r_state == ACCESS) && !bus.PREADY &&
                 (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_tmo        = 1'b0;
`endif

  assign w_end  = (r_state == ACCESS) && (bus.PREADY || w_tmo);
  // the finishing requester may still hold req; skip it this round
  assign w_mask = (r_state == ACCESS) ? (bus.req & ~r_win_oh) : bus.req;
  assign w_arb  = w_any && ((r_state == IDLE) || w_end);

  apb_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req (w_mask),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_psel      = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = SETUP;
      end
      SETUP: begin
        w_psel      = psel_decode(r_paddr[AW-1 -: SLV_SEL_W]);
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        w_psel = psel_decode(r_paddr[AW-1 -: SLV_SEL_W]);
        if (w_end) w_state_nxt = w_any ? SETUP : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_win_oh <= '0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_done   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= '0;
      if (w_end) begin
        r_done <= r_win_oh;
        r_err  <= w_tmo | bus.PSLVERR;
        if (w_tmo)
          r_rdata <= '0;
        else if (!r_pwrite)
          r_rdata <= bus.PRDATA;
      end
      if (w_arb) begin
        r_win_oh <= w_gnt;
        r_ptr    <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        r_paddr  <= w_addr[w_idx];
        r_pwdata <= w_wdata[w_idx];
        r_pwrite <= bus.req_write[w_idx];
      end
    end
  end

  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PENABLE   = (r_state == ACCESS);
  assign bus.PSEL1     = w_psel[0];
  assign bus.PSEL2     = w_psel[1];
  assign bus.PSEL3     = w_psel[2];
  assign bus.PSEL4     = w_psel[3];
  assign bus.done      = r_done;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
endmodule
